mul_div_arbiter: RTL and testbench
==================================

# mul_div_arbiter

Round-robin arbiter and sequencer that shares one `mul_div` floating-point multiply/divide unit between `N_REQ` requesters. It accepts one operation at a time over a valid/ready request channel and drives the unit's `a`, `b`, `sel` and `en` inputs. After a fixed latency it captures `R` and the five exception flags, then returns them to the originating requester over a valid/ready response channel. It sits between the requester ports and a `mul_div` instance, and contains no arithmetic of its own.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters; must be 2 or more.
- `W`, default 32: operand and result width (IEEE-754 single precision).
- `LATENCY`, default 2: number of cycles from the edge that samples `md_en` to the cycle in which `md_r` and the flags are valid; must be 1 or more.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `arst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit is high in any cycle.
- `req_a`, `req_b`  in  N_REQ*W  packed operands; requester i uses slice [i*W +: W].
- `req_sel`  in  N_REQ  operation select per requester: 0 = multiply, 1 = divide.
- `rsp_valid`  out  N_REQ  per-requester response valid; at most one bit is high.
- `rsp_ready`  in  N_REQ  per-requester response accept.
- `rsp_r`  out  W  registered result; shared by all requesters.
- `rsp_flags`  out  5  registered flags {io, dz, of, uf, i}, bit 4 down to bit 0.
- `md_a`, `md_b`  out  W  operands to the unit.
- `md_sel`  out  1  operation select to the unit.
- `md_en`  out  1  enable to the unit.
- `md_r`  in  W  result from the unit.
- `md_io`, `md_dz`, `md_of`, `md_uf`, `md_i`  in  1 each  flags from the unit.
- `busy`  out  1  high in every state except IDLE.

## Operation
The state machine has four states: IDLE, ISSUE, WAIT and RESP.

- **IDLE**
  - The winner is the first requester with `req_valid` high, searching from `rr_ptr` upward and wrapping modulo N_REQ.
  - `req_ready[winner]` is driven combinationally in the same cycle, so the handshake completes in that cycle.
  - On the handshake: latch the operands and `sel` into `md_a`/`md_b`/`md_sel`, store the winner index in `owner`, and go to ISSUE.
  - If no requester is valid, stay in IDLE.
- **ISSUE**
  - `md_en` is 1 for exactly this one cycle.
  - Load the counter with LATENCY-1, then go to WAIT.
- **WAIT**
  - The counter decrements each cycle.
  - In the cycle the counter reads 0: capture `md_r` into `rsp_r`, capture the flags into `rsp_flags`, and go to RESP.
- **RESP**
  - `rsp_valid[owner]` is 1, and `rsp_r`/`rsp_flags` are held stable.
  - When `rsp_ready[owner]` is 1: set `rr_ptr` to (owner+1) mod N_REQ and go to IDLE.

Rules that apply in all states:
- `req_ready` is 0 in every state except IDLE.
- No new request is accepted until the response handshake has completed. Exactly one operation is in flight at any time.
- `md_a`, `md_b` and `md_sel` hold their last latched values outside IDLE-accept cycles, and are never changed while the unit is busy.
- `rsp_ready` bits belonging to non-owners are ignored.
- `req_valid` that drops before it is granted is not recorded.
- The result and flags are passed through unmodified; there is no rounding, checking or reordering.

## Timing
- On reset: state = IDLE, `rr_ptr` = 0, `owner` = 0, counter = 0.
- All outputs read 0 during and after reset: `req_ready`, `rsp_valid`, `rsp_r`, `rsp_flags`, `md_a`, `md_b`, `md_sel`, `md_en`, `busy`.
- Reset in any state aborts the operation. No response is issued, and `md_en` is 0 on the next cycle.
- Per-operation timeline, with the accept at cycle 0:
  - cycle 1: `md_en` = 1.
  - cycles 2 to LATENCY+1: WAIT.
  - cycle LATENCY+2: `rsp_valid` rises.
- The earliest next accept is the cycle after the response handshake. Peak throughput is therefore one operation every LATENCY+3 cycles.
- Simultaneous requests are granted in round-robin order. Priority after a grant moves to the next index.
- `rr_ptr` wraps from N_REQ-1 to 0.

## Test plan
- **Single multiply:** with `LATENCY` = 2, requester 0 sends a = 0x40400000, b = 0x40000000, sel = 0.
  - Required: `req_ready[0]` at cycle 0, `md_en` pulse at cycle 1, `rsp_valid[0]` at cycle 4.
  - Required: `rsp_r` = 0x40C00000 and `rsp_flags` = 0.
- **Divide by zero:** requester 1 sends 0x3F800000 / 0x00000000 with sel = 1.
  - Required: `rsp_valid[1]`, `rsp_r` = 0x7F800000, `rsp_flags` = 5'b01000.
- **Contention:** both requesters hold `req_valid` from the first cycle after reset.
  - Required: grant order 0, 1, 0, 1.
  - Required: each `rsp_valid` goes only to the owner, and `req_ready` is never high on both bits.
- **Backpressure:** hold `rsp_ready` low for 5 cycles during RESP.
  - Required: `rsp_valid`, `rsp_r` and `rsp_flags` are stable throughout.
  - Required: `req_ready` stays 0 even though requester 1 is valid.
  - Required: the accept follows the cycle after `rsp_ready` rises.
- **Reset mid-operation:** assert `arst` for one cycle during WAIT.
  - Required: no `rsp_valid` is issued, all outputs are 0, and `rr_ptr` = 0.
  - Required: a following request from requester 1 completes normally.
- **Ignored ready:** raise `rsp_ready[1]` while requester 0 owns RESP.
  - Required: there is no state change.

Source files
------------

// File: rtl/mul_div_arbiter.sv
// mul_div_arbiter: round-robin sequencer sharing one mul_div unit between
// N_REQ requesters. One operation in flight at a time; the unit's result and
// flags are captured after LATENCY cycles and returned to the owner.
module mul_div_arbiter #(
  parameter int N_REQ   = 2,
  parameter int W       = 32,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_sel,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W-1:0]       rsp_r,
  output logic [4:0]         rsp_flags,
  output logic [W-1:0]       md_a,
  output logic [W-1:0]       md_b,
  output logic               md_sel,
  output logic               md_en,
  input  logic [W-1:0]       md_r,
  input  logic               md_io,
  input  logic               md_dz,
  input  logic               md_of,
  input  logic               md_uf,
  input  logic               md_i,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_owner;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_md_a;
  logic [W-1:0]     r_md_b;
  logic             r_md_sel;
  logic             r_md_en;
  logic             r_busy;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [W-1:0]     r_rsp_r;
  logic [4:0]       r_rsp_flags;

  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  int               w_sum;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_done;
  logic [N_REQ-1:0] w_req_ready;

  // Round-robin search: first valid requester from r_rr_ptr upward, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_sum   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = int'(r_rr_ptr) + k;
      if (w_sum >= N_REQ) begin
        w_sum = w_sum - N_REQ;
      end else begin
        w_sum = w_sum;
      end
      w_idx = IW'(w_sum);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state logic and per-state strobes; the grant is combinational in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    w_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept    = 1'b1;
          w_req_ready = ONE_HOT0 << w_win;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        // Only the owner's ready bit can complete the response.
        if (rsp_ready[r_owner]) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, latency counter, result capture, pointer and output flops.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_md_a      <= '0;
      r_md_b      <= '0;
      r_md_sel    <= 1'b0;
      r_md_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_r     <= '0;
      r_rsp_flags <= 5'b00000;
    end else begin
      // Operands only change on an accept, so the unit sees stable inputs.
      if (w_accept) begin
        r_md_a   <= req_a[w_win*W +: W];
        r_md_b   <= req_b[w_win*W +: W];
        r_md_sel <= req_sel[w_win];
        r_owner  <= w_win;
      end else begin
        r_md_a   <= r_md_a;
        r_md_b   <= r_md_b;
        r_md_sel <= r_md_sel;
        r_owner  <= r_owner;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end

      if (w_capture) begin
        r_rsp_r     <= md_r;
        r_rsp_flags <= {md_io, md_dz, md_of, md_uf, md_i};
      end else begin
        r_rsp_r     <= r_rsp_r;
        r_rsp_flags <= r_rsp_flags;
      end

      // Priority moves to the index after the owner once it is served.
      if (w_rsp_done) begin
        r_rr_ptr <= (r_owner == LAST_IDX) ? '0 : (r_owner + IW'(1));
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end

      r_md_en     <= (w_state_nxt == S_ISSUE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP) ? (ONE_HOT0 << r_owner) : '0;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_r     = r_rsp_r;
  assign rsp_flags = r_rsp_flags;
  assign md_a      = r_md_a;
  assign md_b      = r_md_b;
  assign md_sel    = r_md_sel;
  assign md_en     = r_md_en;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mul_div_arbiter.sv
// Testbench for mul_div_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model and a
// behavioural stand-in for the mul_div unit.
module tb_mul_div_arbiter;

  localparam int NR  = 3;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            arst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0]   req_sel;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready;
  logic [W-1:0]    rsp_r;
  logic [4:0]      rsp_flags;
  logic [W-1:0]    md_a;
  logic [W-1:0]    md_b;
  logic            md_sel;
  logic            md_en;
  logic [W-1:0]    md_r;
  logic            md_io, md_dz, md_of, md_uf, md_i;
  logic            busy;

  logic [W-1:0]    op_a [NR];
  logic [W-1:0]    op_b [NR];
  logic [NR-1:0]   op_sel;

  int n_checks = 0;
  int n_errors = 0;
  int rr       = 0;
  int got;
  logic [W-1:0] last_r;
  logic [4:0]   last_f;

  mul_div_arbiter #(.N_REQ(NR), .W(W), .LATENCY(LAT)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags),
    .md_a(md_a), .md_b(md_b), .md_sel(md_sel), .md_en(md_en),
    .md_r(md_r), .md_io(md_io), .md_dz(md_dz), .md_of(md_of), .md_uf(md_uf), .md_i(md_i),
    .busy(busy)
  );

  // Pack per-requester operands onto the flat buses.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    req_sel = op_sel;
  end

  // Stand-in unit: known IEEE cases for the directed tests, a scramble otherwise.
  function automatic logic [36:0] unit_out(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (!s && a == 32'h40400000 && b == 32'h40000000) return {5'b00000, 32'h40C00000};
    if (s && a == 32'h3F800000 && b == 32'h00000000) return {5'b01000, 32'h7F800000};
    return {a[4:0] ^ b[9:5] ^ {4'b0000, s}, (a ^ {b[15:0], b[31:16]}) + {31'd0, s}};
  endfunction

  // Unit pipeline: result is valid only LAT cycles after the edge sampling md_en.
  logic [LAT-1:0] pv = '0;
  logic [W-1:0]   pr [LAT];
  logic [4:0]     pf [LAT];
  logic [31:0]    cyc_cnt = 32'd0;
  logic [36:0]    unit_now;
  assign unit_now = unit_out(md_a, md_b, md_sel);
  always @(posedge clk) begin
    pv      <= (pv << 1) | LAT'(md_en);
    pr[0]   <= unit_now[31:0];
    pf[0]   <= unit_now[36:32];
    for (int i = LAT - 1; i > 0; i--) begin
      pr[i] <= pr[i-1];
      pf[i] <= pf[i-1];
    end
    cyc_cnt <= cyc_cnt + 32'd1;
  end
  assign md_r = pv[LAT-1] ? pr[LAT-1] : (32'hBAD00000 ^ cyc_cnt);
  assign {md_io, md_dz, md_of, md_uf, md_i} = pv[LAT-1] ? pf[LAT-1] : (5'h15 ^ cyc_cnt[4:0]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first valid index from rr upward, modulo NR.
  function automatic int model_winner(input logic [NR-1:0] m);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (rr + k) % NR;
      if (((m >> idx) & NR'(1)) != '0) return idx;
    end
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_r"},     64'(rsp_r),     64'd0);
    chk({tag, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
    chk({tag, "_md_a"},      64'(md_a),      64'd0);
    chk({tag, "_md_b"},      64'(md_b),      64'd0);
    chk({tag, "_md_sel"},    64'(md_sel),    64'd0);
    chk({tag, "_md_en"},     64'(md_en),     64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1; req_valid = '0; rsp_ready = '0;
    @(negedge clk); #1;
    check_zero("reset");
    arst = 1'b0;
    rr = 0;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    req_valid = '0; rsp_ready = NR'($urandom()); #1;
    chk("idle_ready",     64'(req_ready), 64'd0);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_busy",      64'(busy),      64'd0);
    chk("idle_md_en",     64'(md_en),     64'd0);
  endtask

  // One complete operation: accept, issue, wait, and a response held for `hold` cycles.
  task automatic txn(input logic [NR-1:0] mask, input int hold, input bit ign, output int g);
    int win; logic [NR-1:0] oh; logic [36:0] e; logic [W-1:0] la, lb; logic ls;
    win = model_winner(mask);
    oh  = NR'(1) << win;
    @(negedge clk);
    req_valid = mask; rsp_ready = '0; #1;
    g = -1;
    for (int i = 0; i < NR; i++) if (g < 0 && ((req_ready >> i) & NR'(1)) != '0) g = i;
    chk("accept_ready", 64'(req_ready), 64'(oh));
    chk("accept_busy",  64'(busy),      64'd0);
    chk("accept_rspv",  64'(rsp_valid), 64'd0);
    la = op_a[win]; lb = op_b[win]; ls = op_sel[win];
    e  = unit_out(la, lb, ls);
    @(negedge clk); #1;
    chk("issue_md_en", 64'(md_en),     64'd1);
    chk("issue_md_a",  64'(md_a),      64'(la));
    chk("issue_md_b",  64'(md_b),      64'(lb));
    chk("issue_sel",   64'(md_sel),    64'(ls));
    chk("issue_ready", 64'(req_ready), 64'd0);
    chk("issue_busy",  64'(busy),      64'd1);
    op_a[win] = $urandom(); op_b[win] = $urandom(); op_sel[win] = 1'($urandom_range(0, 1));
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk); #1;
      chk("wait_md_en", 64'(md_en),     64'd0);
      chk("wait_rspv",  64'(rsp_valid), 64'd0);
      chk("wait_ready", 64'(req_ready), 64'd0);
      chk("wait_busy",  64'(busy),      64'd1);
      chk("wait_md_a",  64'(md_a),      64'(la));
    end
    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      rsp_ready = ign ? ~oh : '0;
      if (c == hold) rsp_ready = rsp_ready | oh;
      #1;
      chk("resp_valid", 64'(rsp_valid), 64'(oh));
      chk("resp_r",     64'(rsp_r),     64'(e[31:0]));
      chk("resp_flags", 64'(rsp_flags), 64'(e[36:32]));
      chk("resp_ready", 64'(req_ready), 64'd0);
      chk("resp_busy",  64'(busy),      64'd1);
      chk("resp_md_en", 64'(md_en),     64'd0);
    end
    last_r = rsp_r;
    last_f = rsp_flags;
    rr = (win + 1) % NR;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = $urandom(); op_b[i] = $urandom();
    end
    op_sel = '0;
    do_reset();

    // Single multiply from requester 0.
    op_a[0] = 32'h40400000; op_b[0] = 32'h40000000; op_sel[0] = 1'b0;
    txn(3'b001, 0, 1'b0, got);
    chk("mul_grant", 64'(got),    64'd0);
    chk("mul_r",     64'(last_r), 64'h40C00000);
    chk("mul_flags", 64'(last_f), 64'd0);

    // Divide by zero from requester 1.
    op_a[1] = 32'h3F800000; op_b[1] = 32'h00000000; op_sel[1] = 1'b1;
    txn(3'b010, 0, 1'b0, got);
    chk("dz_grant", 64'(got),    64'd1);
    chk("dz_r",     64'(last_r), 64'h7F800000);
    chk("dz_flags", 64'(last_f), 64'h08);

    // Backpressure for 5 cycles with requester 1 waiting and its ready ignored.
    txn(3'b011, 5, 1'b1, got);
    chk("bp_grant", 64'(got), 64'd0);
    txn(3'b011, 0, 1'b0, got);
    chk("bp_next_grant", 64'(got), 64'd1);

    // Reset during WAIT aborts the operation and clears the pointer.
    @(negedge clk);
    req_valid = 3'b001; rsp_ready = '0; #1;
    chk("abort_accept", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = '0; #1;
    chk("abort_issue", 64'(md_en), 64'd1);
    @(negedge clk);
    arst = 1'b1; #1;
    chk("abort_in_wait", 64'(busy), 64'd1);
    @(negedge clk);
    arst = 1'b0; #1;
    check_zero("abort");
    rr = 0;
    repeat (4) idle_cyc();
    txn(3'b110, 0, 1'b0, got);
    chk("abort_next_grant", 64'(got), 64'd1);

    // Contention after a clean reset: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(3'b011, 0, 1'b0, got);
      chk("contention_order", 64'(got), 64'(i % 2));
    end

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NR; i++) begin
        op_a[i] = $urandom(); op_b[i] = $urandom(); op_sel[i] = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 2)) idle_cyc();
      txn(NR'($urandom_range(1, (1 << NR) - 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
    end
    idle_cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
